// File: rtl/fitness_pkg.sv
// Shared constants and state encoding for the fitness accumulation stage.
package fitness_pkg;

  // Default geometry of one individual's output vector {y3,y2,y1,y0}
  localparam int N_OUT = 4;
  localparam int OUT_W = 16;
  localparam int VEC_W = N_OUT * OUT_W;
  // Width able to hold a per-vector match count of 0..VEC_W
  localparam int INC_W = $clog2(VEC_W + 1);

  // Controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/fitness_accumulator_hamming.sv
// Combinational Hamming similarity: number of bit positions where a and b agree.
module hamming_score
  import fitness_pkg::*;
#(
  parameter int W  = VEC_W,
  parameter int CW = INC_W
) (
  input  logic [W-1:0]  i_a,
  input  logic [W-1:0]  i_b,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  w_match;
  logic [CW-1:0] w_count;

  assign w_match = ~(i_a ^ i_b);

  // Population count of the agreeing bit positions
  always_comb begin
    w_count = '0;
    for (int b = 0; b < W; b++) begin
      w_count = w_count + CW'(w_match[b]);
    end
  end

  assign o_count = w_count;

endmodule

// File: rtl/fitness_accumulator.sv
// Accumulates per-individual match scores over a fixed number of test vectors,
// then streams the final scores out one per handshake.
module fitness_accumulator
  import fitness_pkg::*;
#(
  parameter int POP_SIZE   = 15,
  parameter int N_OUT      = fitness_pkg::N_OUT,
  parameter int OUT_W      = fitness_pkg::OUT_W,
  parameter int TEST_COUNT = 2,
  parameter int SCORE_W    = 16,
  // Derived widths; not meant to be overridden
  parameter int IDX_W      = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              vec_valid,
  output logic                              vec_ready,
  input  logic [N_OUT*OUT_W-1:0]            vec_expected,
  input  logic [POP_SIZE*N_OUT*OUT_W-1:0]   dut_outputs,
  output logic                              score_valid,
  input  logic                              score_ready,
  output logic [IDX_W-1:0]                  score_index,
  output logic [SCORE_W-1:0]                score,
  output logic                              busy,
  output logic                              done
);

  localparam int VW    = N_OUT * OUT_W;
  localparam int IW    = $clog2(VW + 1);
  localparam int CNT_W = $clog2(TEST_COUNT + 1);
  // Sum wide enough that neither operand can overflow it before clamping
  localparam int SUM_W = ((SCORE_W > IW) ? SCORE_W : IW) + 1;
  localparam logic [SUM_W-1:0] SCORE_MAX = {{(SUM_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

  state_t             r_state;
  logic [CNT_W-1:0]   r_vec_cnt;
  logic [IDX_W-1:0]   r_k;
  logic               r_done;
  logic [SCORE_W-1:0] r_score [POP_SIZE];

  logic [IW-1:0]      w_inc [POP_SIZE];
  logic [SUM_W-1:0]   w_sum [POP_SIZE];
  logic [SCORE_W-1:0] w_sat [POP_SIZE];

  logic w_clear;
  logic w_vec_hs;
  logic w_last_vec;
  logic w_score_hs;
  logic w_last_score;

  assign w_clear      = (r_state == IDLE) && start;
  assign w_vec_hs     = (r_state == ACCUM) && vec_valid;
  assign w_last_vec   = w_vec_hs && (r_vec_cnt == CNT_W'(TEST_COUNT - 1));
  assign w_score_hs   = (r_state == REPORT) && score_ready;
  assign w_last_score = w_score_hs && (r_k == IDX_W'(POP_SIZE - 1));

  // One similarity counter and saturating adder per individual
  genvar gi;
  generate
    for (gi = 0; gi < POP_SIZE; gi++) begin : g_ind
      hamming_score #(
        .W  (VW),
        .CW (IW)
      ) u_ham (
        .i_a     (dut_outputs[gi*VW +: VW]),
        .i_b     (vec_expected),
        .o_count (w_inc[gi])
      );

      assign w_sum[gi] = SUM_W'(r_score[gi]) + SUM_W'(w_inc[gi]);
      assign w_sat[gi] = (w_sum[gi] > SCORE_MAX) ? {SCORE_W{1'b1}}
                                                 : w_sum[gi][SCORE_W-1:0];
    end
  endgenerate

  // Run control: vector counting, report index walk and done pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_vec_cnt <= '0;
      r_k       <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_vec_cnt <= '0;
            r_k       <= '0;
            r_state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_vec_hs) begin
            r_vec_cnt <= r_vec_cnt + CNT_W'(1);
            if (w_last_vec) begin
              r_state <= REPORT;
            end
          end
        end
        REPORT: begin
          if (w_last_score) begin
            r_k     <= '0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else if (w_score_hs) begin
            r_k <= r_k + IDX_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Score array: cleared at run start, bumped on every accepted vector
  always_ff @(posedge clk) begin
    for (int i = 0; i < POP_SIZE; i++) begin
      if (!rst || w_clear) begin
        r_score[i] <= '0;
      end else if (w_vec_hs) begin
        r_score[i] <= w_sat[i];
      end
    end
  end

  assign vec_ready   = (r_state == ACCUM);
  assign score_valid = (r_state == REPORT);
  assign score_index = r_k;
  assign score       = r_score[r_k];
  assign busy        = (r_state != IDLE);
  assign done        = r_done;

endmodule

// File: tb/tb_fitness_accumulator.sv
// Scoreboard bench for fitness_accumulator: a 16-bit score instance and a
// 6-bit score instance run in lockstep on the same stimulus.
module tb_fitness_accumulator;

  localparam int POP = 15;
  localparam int VW  = 64;
  localparam logic [63:0] VA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] VB = 64'hFFFF_0000_A5A5_5A5A;

  logic            clk = 1'b0;
  logic            rst, start, vec_valid, score_ready;
  logic [VW-1:0]   vec_expected;
  logic [POP*VW-1:0] dut_outputs;

  logic            vec_ready, score_valid, busy, done;
  logic [3:0]      score_index;
  logic [15:0]     score;
  logic            vec_ready_6, score_valid_6, busy_6, done_6;
  logic [3:0]      score_index_6;
  logic [5:0]      score_6;

  int checks   = 0;
  int failures = 0;
  int idx_q[$];
  int exp_q[$];
  int exp6_q[$];
  logic [63:0] xmask [POP];
  int exp_score [POP];
  bit expect_done = 0;

  always #5 clk = ~clk;

  fitness_accumulator #(.POP_SIZE(15), .N_OUT(4), .OUT_W(16), .TEST_COUNT(2), .SCORE_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_expected(vec_expected), .dut_outputs(dut_outputs), .score_valid(score_valid),
    .score_ready(score_ready), .score_index(score_index), .score(score), .busy(busy), .done(done)
  );

  fitness_accumulator #(.POP_SIZE(15), .N_OUT(4), .OUT_W(16), .TEST_COUNT(2), .SCORE_W(6)) dut6 (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_ready(vec_ready_6),
    .vec_expected(vec_expected), .dut_outputs(dut_outputs), .score_valid(score_valid_6),
    .score_ready(score_ready), .score_index(score_index_6), .score(score_6), .busy(busy_6), .done(done_6)
  );

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vec_ready"},    vec_ready,     0);
    check({tag, "_score_valid"},  score_valid,   0);
    check({tag, "_score_index"},  score_index,   0);
    check({tag, "_score"},        score,         0);
    check({tag, "_busy"},         busy,          0);
    check({tag, "_done"},         done,          0);
    check({tag, "_score6"},       score_6,       0);
    check({tag, "_busy6"},        busy_6,        0);
    check({tag, "_score_valid6"}, score_valid_6, 0);
  endtask

  task automatic set_exp_all(input int v);
    for (int i = 0; i < POP; i++) begin
      exp_score[i] = v;
      xmask[i]     = 64'h0;
    end
  endtask

  // Push the expected report beats for the run about to be issued
  task automatic push_run();
    for (int i = 0; i < POP; i++) begin
      idx_q.push_back(i);
      exp_q.push_back(exp_score[i]);
      exp6_q.push_back((exp_score[i] > 63) ? 63 : exp_score[i]);
    end
  endtask

  task automatic start_run();
    push_run();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_vec_ready", vec_ready, 1);
  endtask

  task automatic send_vec(input logic [63:0] e, input int gap);
    int n;
    repeat (gap) step();
    vec_expected = e;
    for (int i = 0; i < POP; i++) dut_outputs[i*VW +: VW] = e ^ xmask[i];
    vec_valid = 1'b1;
    n = 0;
    while (!vec_ready && n < 20) begin
      step();
      n++;
    end
    if (!vec_ready) begin
      checks++;
      failures++;
      $display("FAIL vec_ready_timeout actual=0 required=1");
    end
    step();
    vec_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    score_ready = 1'b1;
    n = 0;
    while ((idx_q.size() != 0 || expect_done) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", idx_q.size());
    end
    score_ready = 1'b0;
    check("drain_idle_busy", busy, 0);
    step();
  endtask

  // Monitor: compare every accepted score beat against the scoreboard
  always @(negedge clk) begin
    int i, e, e6;
    if (rst) begin
      if (expect_done) begin
        check("done_pulse", done, 1);
        check("busy_after_done", busy, 0);
        check("done_pulse6", done_6, 1);
        expect_done = 0;
      end else if (done) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected actual=1 required=0");
      end
      if (score_valid && score_ready) begin
        if (idx_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=index%0d required=none", score_index);
        end else begin
          i  = idx_q.pop_front();
          e  = exp_q.pop_front();
          e6 = exp6_q.pop_front();
          check("score_index", score_index, i);
          check("score", score, e);
          check("score_valid6", score_valid_6, 1);
          check("score_index6", score_index_6, i);
          check("score6", score_6, e6);
          $display("beat index=%0d score=%0d score6=%0d", score_index, score, score_6);
          if (i == POP - 1) expect_done = 1;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; vec_valid = 1'b0; score_ready = 1'b0;
    vec_expected = '0; dut_outputs = '0;
    set_exp_all(0);
    repeat (3) step();
    check_zero("reset");
    rst = 1'b1;
    step();

    // All individuals match both vectors
    set_exp_all(128);
    start_run();
    send_vec(VA, 0);
    send_vec(VB, 0);
    check("t1_report_valid", score_valid, 1);
    check("t1_vec_ready_low", vec_ready, 0);
    check("t1_first_index", score_index, 0);
    drain();

    // Individual 3 fully inverted, individual 5 one bit off
    set_exp_all(128);
    xmask[3] = 64'hFFFF_FFFF_FFFF_FFFF; exp_score[3] = 0;
    xmask[5] = 64'h0000_0000_0000_0001; exp_score[5] = 126;
    start_run();
    send_vec(VA, 0);
    send_vec(VB, 0);
    drain();

    // Sparse vec_valid with a start pulse in the middle of ACCUM
    set_exp_all(128);
    xmask[0] = 64'h0000_0000_0000_000F; exp_score[0] = 120;
    start_run();
    send_vec(VA, 2);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    send_vec(VB, 0);
    check("t3_two_hs_report", score_valid, 1);
    check("t3_two_hs_ready", vec_ready, 0);
    drain();

    // Backpressure at index 2
    set_exp_all(128);
    xmask[2] = 64'h8000_0000_0000_0001; exp_score[2] = 124;
    start_run();
    send_vec(VA, 0);
    send_vec(VB, 0);
    score_ready = 1'b1;
    n = 0;
    while (score_index != 4'd2 && n < 20) begin
      step();
      n++;
    end
    score_ready = 1'b0;
    check("t4_reach_index2", score_index, 2);
    for (int c = 0; c < 5; c++) begin
      step();
      check("t4_stall_index", score_index, 2);
      check("t4_stall_score", score, 124);
      check("t4_stall_valid", score_valid, 1);
    end
    score_ready = 1'b1;
    step();
    check("t4_advance_index", score_index, 3);
    drain();

    // Reset in the middle of REPORT, then a fresh run
    set_exp_all(128);
    xmask[3] = 64'hFFFF_FFFF_FFFF_FFFF; exp_score[3] = 0;
    xmask[5] = 64'h0000_0000_0000_0001; exp_score[5] = 126;
    start_run();
    send_vec(VA, 0);
    send_vec(VB, 0);
    score_ready = 1'b1;
    n = 0;
    while (score_index != 4'd7 && n < 20) begin
      step();
      n++;
    end
    score_ready = 1'b0;
    check("t6_reach_index7", score_index, 7);
    rst = 1'b0;
    step();
    check_zero("midreset");
    idx_q.delete();
    exp_q.delete();
    exp6_q.delete();
    rst = 1'b1;
    step();
    set_exp_all(128);
    start_run();
    send_vec(VA, 0);
    send_vec(VB, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fitness_accumulator.md
# fitness_accumulator

Hardware fitness stage that sits directly downstream of the evaluated population of 2-bit-multiplier individuals. Each accepted test vector supplies every individual's {y3,y2,y1,y0} outputs and the expected outputs. The block adds the per-vector bitwise match count (Hamming similarity) into a per-individual score. After the configured number of vectors, it streams the final scores out one per handshake, so the evolutionary loop can read them without a simulator print loop.

## Interface
Parameters:
- POP_SIZE, 15, number of individuals
- N_OUT, 4, output buses per individual (y3..y0)
- OUT_W, 16, width of each output bus
- TEST_COUNT, 2, vectors per evaluation run
- SCORE_W, 16, width of each accumulated score

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  begin an evaluation run (sampled in IDLE only)
- vec_valid  in  1  vector beat valid
- vec_ready  out  1  vector beat accepted when high with vec_valid
- vec_expected  in  N_OUT*OUT_W  packed {y3,y2,y1,y0} expected
- dut_outputs  in  POP_SIZE*N_OUT*OUT_W  individual i at [i*N_OUT*OUT_W +: N_OUT*OUT_W], same packing
- score_valid  out  1  score beat valid
- score_ready  in  1  consumer accepts score beat
- score_index  out  $clog2(POP_SIZE)  individual number of current beat
- score  out  SCORE_W  accumulated score of that individual
- busy  out  1  high in ACCUM and REPORT
- done  out  1  one-cycle pulse after the last score beat

## Operation
- The state machine has three states: IDLE, ACCUM, REPORT.
- IDLE:
  - vec_ready=0, score_valid=0.
  - When start=1, clear all scores and the vector counter, then go to ACCUM.
- ACCUM:
  - vec_ready=1.
  - On each handshake, for every i: score[i] += popcount(~(dut_i ^ vec_expected)). The per-vector increment is 0..N_OUT*OUT_W (0..64).
  - Addition saturates at 2^SCORE_W-1; it never wraps.
  - The vector counter increments per handshake. When the TEST_COUNT-th handshake occurs, go to REPORT.
  - Cycles without a handshake change nothing.
- REPORT:
  - score_valid=1, score_index=k, score=score[k], with k starting at 0.
  - On score_valid&score_ready, k increments.
  - On acceptance of k=POP_SIZE-1, go to IDLE and pulse done.
  - While score_ready=0, score_index and score hold stable.
- start is ignored in ACCUM and REPORT.
- Scores persist in IDLE until the next start.
- Reset (rst=0 at a clk edge), from any state including mid-run:
  - state=IDLE, all scores 0, counter 0, k 0.
  - vec_ready=0, score_valid=0, score_index=0, score=0, busy=0, done=0.

## Timing
- start high at edge t: ACCUM and vec_ready=1 from t+1.
- Vector handshake at edge t: the updated score is visible from t+1, so accumulate latency is 1 cycle.
- Last vector handshake at edge t: REPORT, score_valid=1, index 0 from t+1. The final score for index 0 is already included.
- Score beats: at most one per cycle, so full throughput is POP_SIZE cycles with score_ready held high.
- Last score handshake at edge t: done=1 and IDLE during t+1 only; busy=0 from t+1.
- start and reset in the same cycle: reset wins.

## Structure
- Package fitness_pkg holds:
  - N_OUT, OUT_W, VEC_W=N_OUT*OUT_W
  - INC_W=$clog2(VEC_W+1)
  - the state enum typedef (IDLE, ACCUM, REPORT)
- Sub-module hamming_score:
  - combinational popcount of ~(a^b) over VEC_W bits, with an INC_W-bit output
  - instantiated POP_SIZE times in a generate loop
- Score storage is a POP_SIZE×SCORE_W register array with a read mux on k.

## Test plan
- Default parameters; all individuals equal expected for both vectors -> indices 0..14 emitted in order, each score=128, done pulse one cycle after index 14 accepted.
- Individual 3 outputs ~expected; individual 5 differs by 1 bit each vector; others match -> score[3]=0, score[5]=126, rest 128.
- vec_valid asserted only every third cycle; start pulsed again during ACCUM -> exactly 2 handshakes counted, scores unchanged by the start pulse.
- In REPORT, score_ready low for 5 cycles at index 2 -> score_index=2 and score stable for all 5 cycles; advances to 3 one cycle after score_ready rises.
- SCORE_W=6, all match -> every score saturates at 63, not 0.
- rst=0 for one cycle at index 7 of REPORT -> next cycle: all outputs 0, IDLE. A new start followed by 2 all-match vectors -> scores 128, not accumulated on top of the old values.
